apb4_master_ctrl: RTL and testbench
===================================

APB4_MASTER_CTRL -- requirements
Module: apb4_master_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PADDR/request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; PSTRB width = DATA_WIDTH/8; only 32 is supported.
REQ-003 SHALL have parameter NUM_SLAVES, default 4, number of PSEL lines, range 1-16.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_4000, base of slave window 0.
REQ-005 SHALL have parameter REGION_BITS, default 12, log2 of window size; slave i owns [BASE_ADDR + i*2^REGION_BITS, BASE_ADDR + (i+1)*2^REGION_BITS - 1].
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles before abort, range 1-255.
REQ-007 SHALL have ports, clock and reset first:
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&req_ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_prot  in  3  protection attribute.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 on writes or errors.
- rsp_error  out  1  slave error, decode error, misalignment, or timeout.
- PADDR  out  ADDR_WIDTH; PSEL  out  NUM_SLAVES; PENABLE  out  1; PWRITE  out  1; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8; PPROT  out  3.
- PREADY  in  NUM_SLAVES; PSLVERR  in  NUM_SLAVES; PRDATA  in  NUM_SLAVES*DATA_WIDTH, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-008 SHALL implement the states IDLE, SETUP, ACCESS, and RESP; all outputs SHALL be registered.
REQ-009 SHALL drive req_ready=1 only in IDLE.
REQ-010 On accept in IDLE, SHALL latch addr, wdata, size, prot, and write, then decode.
- Valid and aligned: go to SETUP next cycle.
- Otherwise: go to RESP with rsp_error=1, and SHALL NOT assert PSEL.
REQ-011 SHALL flag a request as misaligned when it is a half with addr[0]=1, or a word with addr[1:0]!=0.
REQ-012 SHALL flag a decode error when the address is below BASE_ADDR or at/above BASE_ADDR + NUM_SLAVES*2^REGION_BITS.
REQ-013 SETUP, one cycle:
- PSEL one-hot at the decoded index; PENABLE=0.
- PADDR, PWRITE, PWDATA, PPROT driven from the latched request.
- Then go to ACCESS.
REQ-014 PSTRB for writes: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111. For reads, PSTRB = 0.
REQ-015 ACCESS:
- PENABLE=1; PSEL and all address/control/data outputs held stable.
- Only PREADY/PSLVERR/PRDATA of the selected slave are sampled.
REQ-016 In ACCESS with selected PREADY=1:
- Capture PSLVERR into rsp_error.
- Capture PRDATA into rsp_rdata on reads, and 0 on writes or when PSLVERR=1.
- Go to RESP.
REQ-017 SHALL count ACCESS cycles with an 8-bit counter cleared on SETUP entry.
- If TIMEOUT_CYCLES cycles elapse with selected PREADY=0: go to RESP with rsp_error=1, rsp_rdata=0.
- PSEL and PENABLE SHALL deassert on that transition.
- PREADY arriving in the same cycle as expiry SHALL win (normal completion).
REQ-018 RESP, one cycle:
- rsp_valid=1; PSEL=0; PENABLE=0.
- Then go to IDLE.
- Minimum spacing between accepts SHALL be 4 cycles for a valid transfer and 2 cycles for an error.
REQ-019 SHALL hold rsp_rdata and rsp_error stable until the next rsp_valid.
REQ-020 SHALL hold PADDR, PWDATA, PWRITE, and PPROT at their last values in IDLE.

Reset
REQ-021 On PRESETn=0, asynchronously:
- State SHALL go to IDLE and the timeout counter to 0.
- Outputs SHALL go to: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0, rsp_valid=0, rsp_rdata=0, rsp_error=0.
- req_ready SHALL be 0 while reset is asserted and 1 on the first cycle after deassertion.
REQ-022 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid; the in-flight request SHALL be discarded.

Verification
REQ-023 Write word 0x0000_5004, data 0xDEADBEEF, slave 1 PREADY=1 -> PSEL=4'b0010 for SETUP then ACCESS, PSTRB=4'b1111, rsp_valid 4 cycles after accept, rsp_error=0.
REQ-024 Read byte 0x0000_4003, slave 0 returns 0x12345678 after 3 wait states -> PSTRB=0, PENABLE high 4 cycles, rsp_rdata=0x12345678.
REQ-025 Write half 0x0000_6002 -> PSTRB=4'b1100; write half 0x0000_6001 -> no PSEL, rsp_error=1 two cycles after accept.
REQ-026 Read 0x0000_8000 (decode error, NUM_SLAVES=4) -> no PSEL, rsp_error=1, rsp_rdata=0.
REQ-027 Slave 2 holds PREADY=0 -> abort after 16 ACCESS cycles, rsp_error=1; repeat with PREADY=1 on cycle 16 -> normal completion.
REQ-028 Assert PRESETn=0 mid-ACCESS -> PSEL and PENABLE clear immediately (asynchronously), no rsp_valid, req_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/apb4_master_ctrl_if.sv
// Bundle of request/response and APB4 bus signals for apb4_master_ctrl.
// The master modport is the controller's view; the slave modport is the environment's view.
interface apb4_master_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  logic                             req_valid;
  logic                             req_ready;
  logic                             req_write;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic [DATA_WIDTH-1:0]            req_wdata;
  logic [1:0]                       req_size;
  logic [2:0]                       req_prot;
  logic                             rsp_valid;
  logic [DATA_WIDTH-1:0]            rsp_rdata;
  logic                             rsp_error;

  logic [ADDR_WIDTH-1:0]            PADDR;
  logic [NUM_SLAVES-1:0]            PSEL;
  logic                             PENABLE;
  logic                             PWRITE;
  logic [DATA_WIDTH-1:0]            PWDATA;
  logic [DATA_WIDTH/8-1:0]          PSTRB;
  logic [2:0]                       PPROT;
  logic [NUM_SLAVES-1:0]            PREADY;
  logic [NUM_SLAVES-1:0]            PSLVERR;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_prot,
    input  PREADY, PSLVERR, PRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_prot,
    output PREADY, PSLVERR, PRDATA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT
  );
endinterface

// File: rtl/apb4_master_ctrl.sv
// APB4 master: accepts one request at a time, decodes it onto one of NUM_SLAVES
// address windows, runs SETUP/ACCESS with a wait-state timeout and returns a one-cycle response.
module apb4_master_ctrl #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_SLAVES     = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_4000,
  parameter int                    REGION_BITS    = 12,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input logic                PCLK,
  input logic                PRESETn,
  apb4_master_ctrl_if.master bus
);

  localparam int         STRB_W   = DATA_WIDTH / 8;
  localparam int         IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lsb[0];
      default: is_misaligned = (lsb != 2'b00);
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] write_strobe(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'b00:   write_strobe = 4'b0001 << lsb;
      2'b01:   write_strobe = 4'b0011 << {lsb[1], 1'b0};
      default: write_strobe = 4'b1111;
    endcase
  endfunction

  state_t                  state_q,     state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
  logic [NUM_SLAVES-1:0]   psel_q,      psel_d;
  logic                    penable_q,   penable_d;
  logic                    pwrite_q,    pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
  logic [STRB_W-1:0]       pstrb_q,     pstrb_d;
  logic [2:0]              pprot_q,     pprot_d;
  logic [IDX_W-1:0]        sel_idx_q,   sel_idx_d;
  logic [7:0]              tmo_cnt_q,   tmo_cnt_d;

  // Window decode of the incoming address; valid only while a request is offered.
  logic [ADDR_WIDTH-1:0]   offset;
  logic [ADDR_WIDTH-1:0]   win_idx;
  logic [IDX_W-1:0]        dec_idx;
  logic                    in_range;
  logic                    req_ok;
  logic [NUM_SLAVES-1:0]   dec_onehot;

  assign offset   = bus.req_addr - BASE_ADDR;
  assign win_idx  = offset >> REGION_BITS;
  assign dec_idx  = win_idx[IDX_W-1:0];
  assign in_range = (bus.req_addr >= BASE_ADDR) && (win_idx < ADDR_WIDTH'(NUM_SLAVES));
  assign req_ok   = in_range && !is_misaligned(bus.req_size, bus.req_addr[1:0]);

  always_comb begin
    dec_onehot          = '0;
    dec_onehot[dec_idx] = 1'b1;
  end

  // Only the selected slave's return signals are ever looked at.
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  assign sel_ready = bus.PREADY[sel_idx_q];
  assign sel_err   = bus.PSLVERR[sel_idx_q];
  assign sel_rdata = bus.PRDATA[sel_idx_q*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    sel_idx_d   = sel_idx_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_ready_q && bus.req_valid) begin
          req_ready_d = 1'b0;
          if (req_ok) begin
            state_d   = S_SETUP;
            psel_d    = dec_onehot;
            sel_idx_d = dec_idx;
            paddr_d   = bus.req_addr;
            pwrite_d  = bus.req_write;
            pwdata_d  = bus.req_wdata;
            pprot_d   = bus.req_prot;
            pstrb_d   = bus.req_write ? write_strobe(bus.req_size, bus.req_addr[1:0]) : '0;
            tmo_cnt_d = '0;
          end else begin
            // Rejected requests never reach the bus; answer straight away.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end

      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end

      S_ACCESS: begin
        // A ready slave beats an expiring timeout in the same cycle.
        if (sel_ready) begin
          state_d     = S_RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = sel_err;
          rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = S_RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        psel_d      = '0;
        penable_d   = 1'b0;
        req_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      sel_idx_q   <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      sel_idx_q   <= sel_idx_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.PPROT     = pprot_q;

endmodule

// File: tb/tb_apb4_master_ctrl.sv
// Self-checking bench for apb4_master_ctrl: scenario tasks drive requests and a
// scoreboard queue holds the expected response for each accepted request.
module tb_apb4_master_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  int   acc_cyc = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;
  exp_t sbq[$];

  apb4_master_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

  apb4_master_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .BASE_ADDR(32'h0000_4000),
    .REGION_BITS(12), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Scoreboard: every response is matched against the oldest expectation.
  always @(negedge PCLK) begin
    exp_t e;
    if (PRESETn && bus.rsp_valid === 1'b1) begin
      n_total++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_unexpected: rsp_valid with err=%b rdata=%h, no response expected",
                 bus.rsp_error, bus.rsp_rdata);
      end else begin
        e = sbq.pop_front();
        if (bus.rsp_error !== e.err || bus.rsp_rdata !== e.rd)
          $display("FAIL sb_rsp: got err=%b rdata=%h want err=%b rdata=%h",
                   bus.rsp_error, bus.rsp_rdata, e.err, e.rd);
        else n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_slaves();
    bus.PREADY  = '1;
    bus.PSLVERR = '1;
    bus.PRDATA  = {NS{32'hBAD0_BAD0}};
  endtask

  // Offer a request; returns at the negedge of the cycle after acceptance.
  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic [2:0] pr,
                      input bit exp_err, input logic [31:0] exp_rd);
    int   n;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_size  = sz;
    bus.req_prot  = pr;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 50) begin
      $display("FAIL accept_timeout: req_ready stayed %b, want 1 within 50 cycles", bus.req_ready);
      $fatal(1, "request never accepted");
    end
    acc_cyc = cyc;
    e.err = exp_err;
    e.rd  = exp_rd;
    sbq.push_back(e);
    @(negedge PCLK);
    bus.req_valid = 1'b0;
  endtask

  // Plays the selected slave until a response appears; records what the bus did.
  task automatic apb_access(input int slave, input int waits, input bit hang, input bit err,
                            input logic [31:0] rdata, output int pen_cnt, output int rsp_at,
                            output logic [3:0] psel_seen, output bit stable_ok);
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    pen_cnt = 0; rsp_at = -1; psel_seen = '0; stable_ok = 1'b1;
    a0 = bus.PADDR; d0 = bus.PWDATA; s0 = bus.PSTRB;
    bus.PRDATA[slave*32 +: 32] = rdata;
    bus.PSLVERR[slave]         = err;
    bus.PREADY[slave]          = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (bus.rsp_valid === 1'b1) begin
        rsp_at = cyc;
        break;
      end
      if (bus.PSEL !== 4'b0000) begin
        if (psel_seen == 4'b0000) psel_seen = bus.PSEL;
        else if (bus.PSEL !== psel_seen) stable_ok = 1'b0;
        if (bus.PADDR !== a0 || bus.PWDATA !== d0 || bus.PSTRB !== s0) stable_ok = 1'b0;
      end
      if (bus.PENABLE === 1'b1) begin
        pen_cnt++;
        if (bus.PSEL === 4'b0000) stable_ok = 1'b0;
        bus.PREADY[slave] = !hang && (pen_cnt > waits);
      end else begin
        bus.PREADY[slave] = 1'b0;
      end
      @(negedge PCLK);
    end
    idle_slaves();
  endtask

  function automatic bit m_err(input logic [31:0] a, input logic [1:0] sz);
    bit mis;
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    return mis || (a < 32'h0000_4000) || (a >= 32'h0000_8000);
  endfunction

  function automatic logic [3:0] m_strb(input bit w, input logic [31:0] a, input logic [1:0] sz);
    if (!w) return 4'b0000;
    case (sz)
      2'b00:   return 4'b0001 << a[1:0];
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic test_reset();
    PRESETn = 1'b1;
    #1 PRESETn = 1'b0;
    @(negedge PCLK);
    n_total++; if (bus.PSEL !== 4'b0)      $display("FAIL rst_psel: got %b want 0", bus.PSEL); else n_pass++;
    n_total++; if (bus.PENABLE !== 1'b0)   $display("FAIL rst_penable: got %b want 0", bus.PENABLE); else n_pass++;
    n_total++; if ({bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT} !== '0)
      $display("FAIL rst_bus: got pwrite=%b paddr=%h pwdata=%h pstrb=%b pprot=%b want all 0",
               bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT); else n_pass++;
    n_total++; if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_error} !== '0)
      $display("FAIL rst_rsp: got valid=%b rdata=%h err=%b want 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_error); else n_pass++;
    n_total++; if (bus.req_ready !== 1'b0) $display("FAIL rst_ready_low: got %b want 0", bus.req_ready); else n_pass++;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    n_total++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", bus.req_ready); else n_pass++;
  endtask

  task automatic test_write_word();
    int pc, ra; logic [3:0] ps; bit ok;
    send(1'b1, 32'h0000_5004, 32'hDEAD_BEEF, 2'b10, 3'b010, 1'b0, 32'h0);
    n_total++; if (bus.PSEL !== 4'b0010)   $display("FAIL ww_psel: got %b want 0010", bus.PSEL); else n_pass++;
    n_total++; if (bus.PENABLE !== 1'b0)   $display("FAIL ww_setup_penable: got %b want 0", bus.PENABLE); else n_pass++;
    n_total++; if (bus.PSTRB !== 4'b1111)  $display("FAIL ww_pstrb: got %b want 1111", bus.PSTRB); else n_pass++;
    n_total++; if (bus.PADDR !== 32'h5004 || bus.PWDATA !== 32'hDEAD_BEEF || bus.PWRITE !== 1'b1 || bus.PPROT !== 3'b010)
      $display("FAIL ww_ctrl: got paddr=%h pwdata=%h pwrite=%b pprot=%b want 00005004 deadbeef 1 010",
               bus.PADDR, bus.PWDATA, bus.PWRITE, bus.PPROT); else n_pass++;
    apb_access(1, 0, 1'b0, 1'b0, 32'hCAFE_0001, pc, ra, ps, ok);
    n_total++; if (pc !== 1)               $display("FAIL ww_access_cycles: got %0d want 1", pc); else n_pass++;
    n_total++; if (ra - acc_cyc + 1 !== 4) $display("FAIL ww_latency: got %0d want 4", ra - acc_cyc + 1); else n_pass++;
    n_total++; if (!ok)                    $display("FAIL ww_stable: got unstable bus want stable"); else n_pass++;
    @(negedge PCLK); @(negedge PCLK);
    n_total++; if (bus.PADDR !== 32'h5004 || bus.PWDATA !== 32'hDEAD_BEEF)
      $display("FAIL ww_idle_hold: got paddr=%h pwdata=%h want 00005004 deadbeef", bus.PADDR, bus.PWDATA); else n_pass++;
  endtask

  task automatic test_read_wait();
    int pc, ra; logic [3:0] ps; bit ok;
    send(1'b0, 32'h0000_4003, 32'h1111_2222, 2'b00, 3'b001, 1'b0, 32'h1234_5678);
    n_total++; if (bus.PSEL !== 4'b0001)  $display("FAIL rd_psel: got %b want 0001", bus.PSEL); else n_pass++;
    n_total++; if (bus.PSTRB !== 4'b0000) $display("FAIL rd_pstrb: got %b want 0000", bus.PSTRB); else n_pass++;
    apb_access(0, 3, 1'b0, 1'b0, 32'h1234_5678, pc, ra, ps, ok);
    n_total++; if (pc !== 4)               $display("FAIL rd_penable_cycles: got %0d want 4", pc); else n_pass++;
    n_total++; if (ra - acc_cyc + 1 !== 7) $display("FAIL rd_latency: got %0d want 7", ra - acc_cyc + 1); else n_pass++;
    n_total++; if (!ok)                    $display("FAIL rd_stable: got unstable bus want stable"); else n_pass++;
    @(negedge PCLK); @(negedge PCLK);
    n_total++; if (bus.rsp_rdata !== 32'h1234_5678 || bus.rsp_error !== 1'b0)
      $display("FAIL rd_rsp_hold: got rdata=%h err=%b want 12345678 0", bus.rsp_rdata, bus.rsp_error); else n_pass++;
  endtask

  task automatic test_half_and_byte();
    int pc, ra; logic [3:0] ps; bit ok;
    send(1'b1, 32'h0000_6002, 32'h0000_ABCD, 2'b01, 3'b000, 1'b0, 32'h0);
    n_total++; if (bus.PSEL !== 4'b0100)  $display("FAIL hw_psel: got %b want 0100", bus.PSEL); else n_pass++;
    n_total++; if (bus.PSTRB !== 4'b1100) $display("FAIL hw_pstrb: got %b want 1100", bus.PSTRB); else n_pass++;
    apb_access(2, 1, 1'b0, 1'b0, 32'h7777_7777, pc, ra, ps, ok);
    n_total++; if (pc !== 2) $display("FAIL hw_access_cycles: got %0d want 2", pc); else n_pass++;
    send(1'b1, 32'h0000_6001, 32'h0000_ABCD, 2'b01, 3'b000, 1'b1, 32'h0);
    n_total++; if (bus.PSEL !== 4'b0000) $display("FAIL mis_psel: got %b want 0000", bus.PSEL); else n_pass++;
    apb_access(0, 0, 1'b0, 1'b0, 32'h0, pc, ra, ps, ok);
    n_total++; if (ra - acc_cyc + 1 !== 2) $display("FAIL mis_latency: got %0d want 2", ra - acc_cyc + 1); else n_pass++;
    n_total++; if (ps !== 4'b0000 || pc !== 0) $display("FAIL mis_no_bus: got psel=%b penable_cycles=%0d want 0000 0", ps, pc); else n_pass++;
    send(1'b1, 32'h0000_7003, 32'h0000_00EE, 2'b00, 3'b100, 1'b0, 32'h0);
    n_total++; if (bus.PSEL !== 4'b1000 || bus.PSTRB !== 4'b1000)
      $display("FAIL bw_psel_pstrb: got psel=%b pstrb=%b want 1000 1000", bus.PSEL, bus.PSTRB); else n_pass++;
    apb_access(3, 0, 1'b0, 1'b0, 32'h0, pc, ra, ps, ok);
  endtask

  task automatic test_decode_err();
    int pc, ra; logic [3:0] ps; bit ok;
    send(1'b0, 32'h0000_8000, 32'h0, 2'b10, 3'b000, 1'b1, 32'h0);
    apb_access(0, 0, 1'b0, 1'b0, 32'h5555_5555, pc, ra, ps, ok);
    n_total++; if (ps !== 4'b0000) $display("FAIL dec_hi_psel: got %b want 0000", ps); else n_pass++;
    n_total++; if (ra - acc_cyc + 1 !== 2) $display("FAIL dec_hi_latency: got %0d want 2", ra - acc_cyc + 1); else n_pass++;
    send(1'b0, 32'h0000_3FFC, 32'h0, 2'b10, 3'b000, 1'b1, 32'h0);
    apb_access(0, 0, 1'b0, 1'b0, 32'h5555_5555, pc, ra, ps, ok);
    n_total++; if (ps !== 4'b0000) $display("FAIL dec_lo_psel: got %b want 0000", ps); else n_pass++;
    send(1'b0, 32'h0000_7FFC, 32'h0, 2'b10, 3'b000, 1'b0, 32'h0F0F_1234);
    n_total++; if (bus.PSEL !== 4'b1000) $display("FAIL dec_top_psel: got %b want 1000", bus.PSEL); else n_pass++;
    apb_access(3, 0, 1'b0, 1'b0, 32'h0F0F_1234, pc, ra, ps, ok);
  endtask

  task automatic test_slverr();
    int pc, ra; logic [3:0] ps; bit ok;
    send(1'b0, 32'h0000_5000, 32'h0, 2'b10, 3'b000, 1'b1, 32'h0);
    apb_access(1, 1, 1'b0, 1'b1, 32'h55AA_55AA, pc, ra, ps, ok);
    n_total++; if (pc !== 2) $display("FAIL slverr_cycles: got %0d want 2", pc); else n_pass++;
  endtask

  task automatic test_timeout();
    int pc, ra; logic [3:0] ps; bit ok;
    send(1'b0, 32'h0000_6000, 32'h0, 2'b10, 3'b000, 1'b1, 32'h0);
    apb_access(2, 0, 1'b1, 1'b0, 32'h9999_9999, pc, ra, ps, ok);
    n_total++; if (pc !== 16) $display("FAIL tmo_cycles: got %0d want 16", pc); else n_pass++;
    n_total++; if (bus.PSEL !== 4'b0000 || bus.PENABLE !== 1'b0)
      $display("FAIL tmo_release: got psel=%b penable=%b want 0000 0", bus.PSEL, bus.PENABLE); else n_pass++;
    send(1'b0, 32'h0000_6000, 32'h0, 2'b10, 3'b000, 1'b0, 32'hA5A5_0F0F);
    apb_access(2, 15, 1'b0, 1'b0, 32'hA5A5_0F0F, pc, ra, ps, ok);
    n_total++; if (pc !== 16) $display("FAIL tmo_edge_cycles: got %0d want 16", pc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [6];
    logic [1:0]  sizes [6];
    int pc, ra, prev_acc, slave; logic [3:0] ps; bit ok, e, prev_e, w;
    logic [31:0] rd;
    addrs = '{32'h0000_4000, 32'h0000_4002, 32'h0000_5FFE, 32'h0000_9000, 32'h0000_7001, 32'h0000_4FFC};
    sizes = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
    prev_acc = 0; prev_e = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w  = (i % 2) == 1;
      e  = m_err(addrs[i], sizes[i]);
      rd = $urandom;
      slave = e ? 0 : int'((addrs[i] - 32'h0000_4000) >> 12);
      send(w, addrs[i], $urandom, sizes[i], 3'(i), e, (w || e) ? 32'h0 : rd);
      if (e) begin
        n_total++; if (bus.PSEL !== 4'b0000) $display("FAIL b2b_err_psel[%0d]: got %b want 0000", i, bus.PSEL); else n_pass++;
      end else begin
        n_total++; if (bus.PSEL !== (4'b0001 << slave) || bus.PSTRB !== m_strb(w, addrs[i], sizes[i]))
          $display("FAIL b2b_psel_pstrb[%0d]: got psel=%b pstrb=%b want %b %b", i, bus.PSEL, bus.PSTRB,
                   4'b0001 << slave, m_strb(w, addrs[i], sizes[i])); else n_pass++;
      end
      if (i > 0) begin
        n_total++; if (acc_cyc - prev_acc !== (prev_e ? 2 : 4))
          $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, acc_cyc - prev_acc, prev_e ? 2 : 4); else n_pass++;
      end
      prev_acc = acc_cyc;
      prev_e   = e;
      apb_access(slave, 0, 1'b0, 1'b0, rd, pc, ra, ps, ok);
    end
  endtask

  task automatic test_reset_mid_access();
    int pc, ra, seen; logic [3:0] ps; bit ok;
    send(1'b0, 32'h0000_6004, 32'h0, 2'b10, 3'b000, 1'b0, 32'h0);
    void'(sbq.pop_back());
    bus.PREADY[2] = 1'b0;
    @(negedge PCLK); @(negedge PCLK);
    n_total++; if (bus.PENABLE !== 1'b1 || bus.PSEL !== 4'b0100)
      $display("FAIL rmid_in_access: got psel=%b penable=%b want 0100 1", bus.PSEL, bus.PENABLE); else n_pass++;
    #2 PRESETn = 1'b0;
    #1;
    n_total++; if (bus.PSEL !== 4'b0000 || bus.PENABLE !== 1'b0)
      $display("FAIL rmid_async_clear: got psel=%b penable=%b want 0000 0", bus.PSEL, bus.PENABLE); else n_pass++;
    @(negedge PCLK);
    n_total++; if (bus.req_ready !== 1'b0) $display("FAIL rmid_ready_low: got %b want 0", bus.req_ready); else n_pass++;
    PRESETn = 1'b1;
    idle_slaves();
    @(negedge PCLK);
    n_total++; if (bus.req_ready !== 1'b1) $display("FAIL rmid_ready_after: got %b want 1", bus.req_ready); else n_pass++;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.rsp_valid === 1'b1 || bus.PSEL !== 4'b0000) seen++;
      @(negedge PCLK);
    end
    n_total++; if (seen !== 0) $display("FAIL rmid_no_rsp: got %0d active cycles want 0", seen); else n_pass++;
    send(1'b0, 32'h0000_4000, 32'h0, 2'b10, 3'b000, 1'b0, 32'h0BAD_F00D);
    apb_access(0, 0, 1'b0, 1'b0, 32'h0BAD_F00D, pc, ra, ps, ok);
    n_total++; if (ra - acc_cyc + 1 !== 4) $display("FAIL rmid_recover_latency: got %0d want 4", ra - acc_cyc + 1); else n_pass++;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_size  = 2'b00;
    bus.req_prot  = 3'b000;
    idle_slaves();
    test_reset();
    test_write_word();
    test_read_wait();
    test_half_and_byte();
    test_decode_err();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    @(negedge PCLK); @(negedge PCLK);
    n_total++; if (sbq.size() !== 0) $display("FAIL sb_drain: got %0d pending want 0", sbq.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
